// File: rtl/scu_dispatch.sv
// scu_dispatch: job FIFO in front of the SCU. Issues one buffered MAC-count
// job at a time over the start/done handshake and keeps per-job and
// aggregate (saturating) cycle statistics for the performance counters.
module scu_dispatch #(
   parameter int unsigned MULT_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STAT_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [MULT_WIDTH-1:0]         in_mults,
   output logic                          scu_start,
   output logic [MULT_WIDTH-1:0]         scu_mults,
   input  logic                          scu_busy,
   input  logic                          scu_done,
   input  logic [MULT_WIDTH-1:0]         scu_cycles,
   input  logic                          clear_stats,
   output logic                          job_done,
   output logic [MULT_WIDTH-1:0]         job_cycles,
   output logic [STAT_WIDTH-1:0]         total_cycles,
   output logic [STAT_WIDTH-1:0]         jobs_completed,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          idle,
   output logic                          proto_err
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned AW = ((MULT_WIDTH > STAT_WIDTH) ? MULT_WIDTH : STAT_WIDTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_e;

   state_e                 state_q;
   logic [MULT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]          count_q, count_d;
   logic                   scu_start_q, job_done_q, proto_err_q;
   logic [MULT_WIDTH-1:0]  scu_mults_q;
   logic [MULT_WIDTH-1:0]  job_cycles_q, job_cycles_d;
   logic [STAT_WIDTH-1:0]  total_q, total_d;
   logic [STAT_WIDTH-1:0]  jobs_q, jobs_d;
   logic [STAT_WIDTH-1:0]  total_base, jobs_base;
   logic [AW-1:0]          sum_w;
   logic                   push_w, pop_w, done_ok_w;

   assign in_ready  = (count_q < DEPTH_C);
   assign idle      = (state_q == ST_IDLE) && (count_q == '0);
   assign push_w    = in_valid && in_ready;
   assign pop_w     = (state_q == ST_IDLE) && (count_q != '0) && !scu_busy;
   assign done_ok_w = scu_done && (state_q == ST_WAIT);

   assign scu_start      = scu_start_q;
   assign scu_mults      = scu_mults_q;
   assign job_done       = job_done_q;
   assign job_cycles     = job_cycles_q;
   assign total_cycles   = total_q;
   assign jobs_completed = jobs_q;
   assign fifo_count     = count_q;
   assign proto_err      = proto_err_q;

   // Occupancy next-state: simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_d = count_q;
      case ({push_w, pop_w})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Statistics next-state; a clear coincident with an accepted done restarts
   // the sums from zero so the accepted job still counts.
   always_comb begin
      total_base   = clear_stats ? '0 : total_q;
      jobs_base    = clear_stats ? '0 : jobs_q;
      sum_w        = AW'(total_base) + AW'(scu_cycles);
      total_d      = total_base;
      jobs_d       = jobs_base;
      job_cycles_d = clear_stats ? '0 : job_cycles_q;
      if (done_ok_w) begin
         total_d      = (|sum_w[AW-1:STAT_WIDTH]) ? '1 : sum_w[STAT_WIDTH-1:0];
         jobs_d       = (&jobs_base) ? jobs_base : jobs_base + STAT_WIDTH'(1);
         job_cycles_d = scu_cycles;
      end
   end

   // FIFO storage; no reset needed since entries are read only when counted.
   always_ff @(posedge clk) begin
      if (push_w) mem_q[wr_ptr_q] <= in_mults;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_w) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_w)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   // Issue FSM with registered handshake outputs and sticky protocol error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         scu_start_q <= 1'b0;
         scu_mults_q <= '0;
         job_done_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         scu_start_q <= 1'b0;
         job_done_q  <= 1'b0;
         if (scu_done && (state_q != ST_WAIT)) proto_err_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (pop_w) begin
                  scu_mults_q <= mem_q[rd_ptr_q];
                  scu_start_q <= 1'b1;
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: state_q <= ST_WAIT;
            ST_WAIT: begin
               if (scu_done) begin
                  job_done_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_q      <= '0;
         jobs_q       <= '0;
         job_cycles_q <= '0;
      end else begin
         total_q      <= total_d;
         jobs_q       <= jobs_d;
         job_cycles_q <= job_cycles_d;
      end
   end

endmodule

// File: tb/tb_scu_dispatch.sv
// Directed testbench for scu_dispatch with a small SCU model taking
// ceil(m/18) cycles, plus a manual-handshake mode and an 8-bit-stat instance.
module tb_scu_dispatch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_mults = '0;
   logic        scu_start;
   logic [31:0] scu_mults;
   logic        scu_busy, scu_done;
   logic [31:0] scu_cycles;
   logic        clear_stats = 1'b0;
   logic        job_done;
   logic [31:0] job_cycles, total_cycles, jobs_completed;
   logic [2:0]  fifo_count;
   logic        idle, proto_err;

   // SCU model / manual drive selection
   logic        model_en = 1'b1;
   logic        model_done = 1'b0, model_busy = 1'b0;
   logic [31:0] model_cycles = '0;
   logic        man_done = 1'b0, man_busy = 1'b0;
   logic [31:0] man_cycles = '0;

   assign scu_done   = model_en ? model_done   : man_done;
   assign scu_busy   = model_en ? model_busy   : man_busy;
   assign scu_cycles = model_en ? model_cycles : man_cycles;

   // 8-bit statistics instance for saturation
   logic        s_in_valid = 1'b0, s_in_ready;
   logic [31:0] s_in_mults = '0;
   logic        s_start, s_done = 1'b0, s_job_done, s_idle, s_perr;
   logic [31:0] s_mults, s_cycles = '0, s_job_cycles;
   logic [7:0]  s_total, s_jobs;
   logic [2:0]  s_count;

   int unsigned vec = 0;
   int unsigned miscmp = 0;
   int unsigned start_cnt = 0, done_cnt = 0;
   logic [31:0] iss_q[$];
   logic [31:0] cyc_q[$];

   logic [31:0] stream_m [7] = '{32'd0, 32'd1, 32'd18, 32'd19, 32'd36, 32'd100, 32'd1024};
   logic [31:0] stream_c [7] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd6, 32'd57};
   logic [31:0] bp_m [6]     = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16};

   scu_dispatch #(.MULT_WIDTH(32), .FIFO_DEPTH(4), .STAT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mults(in_mults), .scu_start(scu_start), .scu_mults(scu_mults),
      .scu_busy(scu_busy), .scu_done(scu_done), .scu_cycles(scu_cycles),
      .clear_stats(clear_stats), .job_done(job_done), .job_cycles(job_cycles),
      .total_cycles(total_cycles), .jobs_completed(jobs_completed),
      .fifo_count(fifo_count), .idle(idle), .proto_err(proto_err)
   );

   scu_dispatch #(.MULT_WIDTH(32), .FIFO_DEPTH(4), .STAT_WIDTH(8)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_mults(s_in_mults), .scu_start(s_start), .scu_mults(s_mults),
      .scu_busy(1'b0), .scu_done(s_done), .scu_cycles(s_cycles),
      .clear_stats(1'b0), .job_done(s_job_done), .job_cycles(s_job_cycles),
      .total_cycles(s_total), .jobs_completed(s_jobs),
      .fifo_count(s_count), .idle(s_idle), .proto_err(s_perr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   // SCU behavioural model: after seeing start, done follows after
   // max(ceil(m/18),1) cycles and reports ceil(m/18).
   initial begin
      int unsigned cnt;
      int unsigned lat;
      cnt = 0;
      lat = 0;
      forever begin
         @(posedge clk); #1;
         model_done = 1'b0;
         if (!rst_n) begin
            cnt = 0;
            model_busy = 1'b0;
         end else if (cnt != 0) begin
            cnt--;
            if (cnt == 0) begin
               model_done   = 1'b1;
               model_cycles = lat;
               model_busy   = 1'b0;
            end
         end else if (scu_start === 1'b1 && model_en) begin
            lat = (scu_mults + 17) / 18;
            cnt = (lat == 0) ? 1 : lat;
            model_busy = 1'b1;
         end
      end
   end

   // Monitor: records issued jobs and completed-job cycle counts.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (scu_start === 1'b1) begin start_cnt++; iss_q.push_back(scu_mults); end
         if (job_done === 1'b1)  begin done_cnt++;  cyc_q.push_back(job_cycles); end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         miscmp++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] m);
      for (int i = 0; i < 200 && in_ready !== 1'b1; i++) step();
      chk("push_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_mults = m;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_jobs(input logic [31:0] n);
      for (int i = 0; i < 3000 && !(jobs_completed === n && idle === 1'b1); i++) step();
      chk("wait_jobs", 64'(jobs_completed), 64'(n));
   endtask

   // Backpressure feeder: offers bp_m[idx] while jobs remain.
   task automatic feed_step(inout int unsigned idx);
      logic rdy;
      in_valid = (idx < 6);
      if (idx < 6) in_mults = bp_m[idx];
      rdy = in_ready;
      step();
      if (idx < 6 && rdy) idx++;
      if (idx >= 6) in_valid = 1'b0;
   endtask

   initial begin
      int unsigned base;
      int unsigned idx;

      // ---- reset ----
      rst_n = 1'b0;
      step(); step();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_fifo_count", 64'(fifo_count), 64'd0);
      chk("rst_total", 64'(total_cycles), 64'd0);
      chk("rst_jobs", 64'(jobs_completed), 64'd0);
      chk("rst_job_cycles", 64'(job_cycles), 64'd0);
      chk("rst_start", 64'(scu_start), 64'd0);
      chk("rst_perr", 64'(proto_err), 64'd0);
      rst_n = 1'b1;
      step();

      // ---- single job 19 ----
      push(32'd19);
      chk("single_count_after_push", 64'(fifo_count), 64'd1);
      chk("single_no_start_yet", 64'(scu_start), 64'd0);
      step();
      chk("single_start", 64'(scu_start), 64'd1);
      chk("single_mults", 64'(scu_mults), 64'd19);
      chk("single_count_after_pop", 64'(fifo_count), 64'd0);
      step();
      chk("single_start_one_cycle", 64'(scu_start), 64'd0);
      wait_jobs(32'd1);
      step();
      chk("single_job_cycles", 64'(job_cycles), 64'd2);
      chk("single_total", 64'(total_cycles), 64'd2);
      chk("single_jobs", 64'(jobs_completed), 64'd1);
      chk("single_start_cnt", 64'(start_cnt), 64'd1);
      chk("single_done_cnt", 64'(done_cnt), 64'd1);

      // ---- ordered stream ----
      clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
      chk("clear_total", 64'(total_cycles), 64'd0);
      chk("clear_jobs", 64'(jobs_completed), 64'd0);
      chk("clear_job_cycles", 64'(job_cycles), 64'd0);
      base = iss_q.size();
      for (int k = 0; k < 7; k++) push(stream_m[k]);
      wait_jobs(32'd7);
      step();
      chk("stream_issued", 64'(iss_q.size() - base), 64'd7);
      chk("stream_done", 64'(cyc_q.size() - base), 64'd7);
      for (int k = 0; k < 7; k++) begin
         if (base + k < iss_q.size()) chk("stream_order", 64'(iss_q[base+k]), 64'(stream_m[k]));
         if (base + k < cyc_q.size()) chk("stream_cycles", 64'(cyc_q[base+k]), 64'(stream_c[k]));
      end
      chk("stream_total", 64'(total_cycles), 64'd69);
      chk("stream_jobs", 64'(jobs_completed), 64'd7);
      chk("stream_idle", 64'(idle), 64'd1);

      // ---- backpressure (manual SCU) ----
      model_en = 1'b0;
      base = iss_q.size();
      idx = 0;
      repeat (10) feed_step(idx);
      chk("bp_accepted", 64'(idx), 64'd5);
      chk("bp_count_full", 64'(fifo_count), 64'd4);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_mults_held", 64'(scu_mults), 64'd11);
      chk("bp_not_idle", 64'(idle), 64'd0);
      chk("bp_one_issued", 64'(iss_q.size() - base), 64'd1);
      man_done = 1'b1; man_cycles = 32'd3;
      feed_step(idx);
      man_done = 1'b0;
      chk("bp_job_done", 64'(job_done), 64'd1);
      chk("bp_job_cycles", 64'(job_cycles), 64'd3);
      chk("bp_held_6th", 64'(idx), 64'd5);
      feed_step(idx);
      chk("bp_pop_start", 64'(scu_start), 64'd1);
      chk("bp_pop_mults", 64'(scu_mults), 64'd12);
      chk("bp_pop_count", 64'(fifo_count), 64'd3);
      feed_step(idx);
      chk("bp_6th_accepted", 64'(idx), 64'd6);
      chk("bp_refill_count", 64'(fifo_count), 64'd4);
      for (int k = 0; k < 5; k++) begin
         man_done = 1'b1; man_cycles = 32'd1;
         feed_step(idx);
         man_done = 1'b0;
         feed_step(idx);
         feed_step(idx);
      end
      chk("bp_issued", 64'(iss_q.size() - base), 64'd6);
      for (int k = 0; k < 6; k++)
         if (base + k < iss_q.size()) chk("bp_order", 64'(iss_q[base+k]), 64'(bp_m[k]));
      chk("bp_jobs", 64'(jobs_completed), 64'd13);
      chk("bp_total", 64'(total_cycles), 64'd77);
      chk("bp_idle", 64'(idle), 64'd1);
      chk("bp_count_empty", 64'(fifo_count), 64'd0);

      // ---- clear_stats coincident with done ----
      clear_stats = 1'b1; step(); clear_stats = 1'b0;
      push(32'd5); step(); step();
      man_done = 1'b1; man_cycles = 32'd10; step(); man_done = 1'b0;
      chk("pre_clear_total", 64'(total_cycles), 64'd10);
      push(32'd5); step(); step();
      man_done = 1'b1; man_cycles = 32'd6; clear_stats = 1'b1;
      step();
      man_done = 1'b0; clear_stats = 1'b0;
      chk("clrdone_total", 64'(total_cycles), 64'd6);
      chk("clrdone_jobs", 64'(jobs_completed), 64'd1);
      chk("clrdone_job_cycles", 64'(job_cycles), 64'd6);
      chk("clrdone_job_done", 64'(job_done), 64'd1);

      // ---- spurious done in IDLE ----
      chk("pre_spur_perr", 64'(proto_err), 64'd0);
      man_done = 1'b1; man_cycles = 32'd99; step(); man_done = 1'b0;
      chk("spur_perr", 64'(proto_err), 64'd1);
      chk("spur_total", 64'(total_cycles), 64'd6);
      chk("spur_jobs", 64'(jobs_completed), 64'd1);
      chk("spur_job_cycles", 64'(job_cycles), 64'd6);
      chk("spur_no_job_done", 64'(job_done), 64'd0);
      clear_stats = 1'b1; step(); clear_stats = 1'b0;
      step();
      chk("spur_perr_sticky", 64'(proto_err), 64'd1);
      chk("spur_clear_total", 64'(total_cycles), 64'd0);

      // ---- reset during WAIT ----
      push(32'd7); step(); step();
      chk("rw_busy", 64'(idle), 64'd0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step(); step();
      chk("rw_jobs", 64'(jobs_completed), 64'd0);
      chk("rw_perr", 64'(proto_err), 64'd0);
      chk("rw_idle", 64'(idle), 64'd1);
      chk("rw_count", 64'(fifo_count), 64'd0);
      chk("rw_in_ready", 64'(in_ready), 64'd1);
      chk("rw_start", 64'(scu_start), 64'd0);

      // ---- saturation on 8-bit statistics ----
      s_in_valid = 1'b1; s_in_mults = 32'd7; step(); s_in_valid = 1'b0;
      step(); step();
      s_done = 1'b1; s_cycles = 32'd250; step(); s_done = 1'b0;
      chk("sat_preload", 64'(s_total), 64'd250);
      s_in_valid = 1'b1; s_in_mults = 32'd8; step(); s_in_valid = 1'b0;
      step(); step();
      s_done = 1'b1; s_cycles = 32'd10; step(); s_done = 1'b0;
      chk("sat_total", 64'(s_total), 64'd255);
      chk("sat_jobs", 64'(s_jobs), 64'd2);
      chk("sat_job_cycles", 64'(s_job_cycles), 64'd10);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
